// File: rtl/ahb_apb_bridge_mc.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_mc
//
// Purpose:
//   Single-clock AHB-to-APB bridge. It fans out to up to 16 APB slaves and
//   decodes the slave from a 4-bit index field in HADDR. Each AHB transfer
//   is turned into one APB SETUP/ACCESS pair. An out-of-range slave index,
//   a slave error or an ACCESS-phase timeout all produce the standard
//   two-cycle AHB ERROR response.
//
// Ports:
//   clk, HRESETn      clock (rising edge) and asynchronous active-low reset
//   HSELAHB, HADDR,   AHB address phase: select, address, transfer type,
//   HTRANS, HWRITE    and direction
//   HWDATA            AHB write data, valid in the cycle after the address
//   HRDATA            registered read data returned to the AHB master
//   HREADY, HRESP     AHB ready / error response
//   PADDR, PWDATA,    APB address, write data and direction. These are held
//   PWRITE            stable from SETUP through the end of ACCESS.
//   PSEL, PENABLE     one-hot APB slave select and access-phase strobe
//   PRDATA, PREADY,   per-slave APB read data (slice i), ready and error
//   PSLVERR
// ---------------------------------------------------------------------------
module ahb_apb_bridge_mc #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      HRESETn,
  input  logic                      HSELAHB,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [DATA_W-1:0]         HWDATA,
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADY,
  output logic                      HRESP,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [3:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                apb_active;
  logic                xfer_valid;
  logic                idx_bad;
  logic                timeout_hit;
  logic [NUM_SLV-1:0]  psel_vec;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  // HREADY is high only in the two states that can take a new address
  // phase. That also makes the "valid transfer" qualifier state-aware.
  assign HREADY     = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign HRESP      = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign apb_active = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign xfer_valid = HSELAHB && HTRANS[1] && HREADY;

  // The index is compared at 5 bits so that NUM_SLV = 16 still works.
  assign idx_bad     = ({1'b0, idx_q} >= 5'(NUM_SLV));
  // The counter holds the number of stalled ACCESS cycles already seen.
  // The current stalled cycle is the one that may reach the limit.
  assign timeout_hit = (({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT_CYC));

  assign PADDR   = addr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = write_q;
  assign PSEL    = psel_vec;
  assign PENABLE = (state_q == S_ACCESS);
  assign HRDATA  = hrdata_q;

  // Slave decode. Only the indexed slave drives PSEL and is listened to.
  // CAPTURE has already rejected out-of-range indices, so at most one bit
  // can match.
  always_comb begin
    psel_vec  = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (apb_active && (idx_q == 4'(i))) begin
        psel_vec[i] = 1'b1;
        sel_ready   = PREADY[i];
        sel_err     = PSLVERR[i];
        sel_rdata   = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and datapath. The address-phase latch is shared by IDLE and
  // ERR2, so it sits ahead of the case statement.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    idx_d    = idx_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;

    if (xfer_valid) begin
      addr_d  = HADDR;
      write_d = HWRITE;
      idx_d   = HADDR[SEL_LSB +: 4];
    end

    case (state_q)
      S_IDLE: begin
        if (xfer_valid) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (write_q) begin
          pwdata_d = HWDATA;
        end
        state_d = idx_bad ? S_ERR1 : S_SETUP;
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d = S_ERR1;
          end else begin
            if (!write_q) begin
              hrdata_d = sel_rdata;
            end
            state_d = S_IDLE;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      S_ERR2: begin
        state_d = xfer_valid ? S_CAPTURE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state resets asynchronously. PSEL and PENABLE are decoded from
  // state, so they drop the moment HRESETn falls.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge_mc
//
// Directed testbench for ahb_apb_bridge_mc with the default parameters
// (4 slaves, slave index at HADDR[15:12], timeout of 16 cycles).
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so each sample shows the state of the cycle that just began.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge_mc;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 4;

  logic                      clk;
  logic                      HRESETn;
  logic                      HSELAHB;
  logic [ADDR_W-1:0]         HADDR;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [DATA_W-1:0]         HWDATA;
  logic [DATA_W-1:0]         HRDATA;
  logic                      HREADY;
  logic                      HRESP;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PWRITE;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  int num_checks;
  int num_errors;
  int access_cycles;

  ahb_apb_bridge_mc #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_SLV    (NUM_SLV),
    .SEL_LSB    (12),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk    (clk),
    .HRESETn(HRESETn),
    .HSELAHB(HSELAHB),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HWRITE (HWRITE),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PWRITE (PWRITE),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every comparison and reports each miscompare.
  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Moves to 1 ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one AHB NONSEQ address phase for the current cycle.
  task automatic apply_stimulus(input logic [ADDR_W-1:0] addr, input logic wr);
    HSELAHB = 1'b1;
    HTRANS  = 2'b10;
    HADDR   = addr;
    HWRITE  = wr;
  endtask

  task automatic ahb_idle();
    HSELAHB = 1'b0;
    HTRANS  = 2'b00;
  endtask

  initial begin
    num_checks = 0;
    num_errors = 0;
    HRESETn = 1'b0;
    HSELAHB = 1'b0;
    HADDR   = '0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    HWDATA  = '0;
    PRDATA  = '0;
    PREADY  = '0;
    PSLVERR = '0;

    // Reset values
    step();
    step();
    check_output("rst_hready", 64'(HREADY), 64'd1);
    check_output("rst_hresp", 64'(HRESP), 64'd0);
    check_output("rst_psel", 64'(PSEL), 64'd0);
    check_output("rst_penable", 64'(PENABLE), 64'd0);
    check_output("rst_hrdata", 64'(HRDATA), 64'd0);
    check_output("rst_paddr", 64'(PADDR), 64'd0);
    check_output("rst_pwdata", 64'(PWDATA), 64'd0);
    check_output("rst_pwrite", 64'(PWRITE), 64'd0);
    HRESETn = 1'b1;
    step();

    // A BUSY transfer is ignored.
    HSELAHB = 1'b1;
    HTRANS  = 2'b01;
    HADDR   = 32'h0000_1000;
    step();
    ahb_idle();
    step();
    check_output("busy_hready", 64'(HREADY), 64'd1);
    check_output("busy_psel", 64'(PSEL), 64'd0);

    // Zero-wait write to slave 1
    PREADY  = 4'b0010;
    PSLVERR = 4'b0000;
    apply_stimulus(32'h0000_1004, 1'b1);
    step();                                     // A+1 CAPTURE
    ahb_idle();
    HWDATA = 32'hDEAD_BEEF;
    check_output("wr_capture_hready", 64'(HREADY), 64'd0);
    check_output("wr_capture_psel", 64'(PSEL), 64'd0);
    step();                                     // A+2 SETUP
    HWDATA = 32'h0;
    check_output("wr_setup_psel", 64'(PSEL), 64'h2);
    check_output("wr_setup_penable", 64'(PENABLE), 64'd0);
    check_output("wr_setup_paddr", 64'(PADDR), 64'h1004);
    check_output("wr_setup_pwrite", 64'(PWRITE), 64'd1);
    check_output("wr_setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
    step();                                     // A+3 ACCESS
    check_output("wr_access_psel", 64'(PSEL), 64'h2);
    check_output("wr_access_penable", 64'(PENABLE), 64'd1);
    check_output("wr_access_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
    check_output("wr_access_hready", 64'(HREADY), 64'd0);
    step();                                     // A+4 IDLE
    check_output("wr_done_hready", 64'(HREADY), 64'd1);
    check_output("wr_done_hresp", 64'(HRESP), 64'd0);
    check_output("wr_done_psel", 64'(PSEL), 64'd0);

    // Read from slave 3 with 3 wait states. Slave 0 is ready and drives
    // other data, but it is not selected and must be ignored.
    PREADY = 4'b0001;
    PRDATA = {32'h1234_5678, 32'h0, 32'h0, 32'hFFFF_0000};
    apply_stimulus(32'h0000_3010, 1'b0);
    step();                                     // A+1
    ahb_idle();
    step();                                     // A+2 SETUP
    check_output("rd_setup_psel", 64'(PSEL), 64'h8);
    check_output("rd_setup_pwrite", 64'(PWRITE), 64'd0);
    check_output("rd_setup_paddr", 64'(PADDR), 64'h3010);
    step();                                     // A+3 ACCESS
    check_output("rd_wait1_hready", 64'(HREADY), 64'd0);
    check_output("rd_wait1_penable", 64'(PENABLE), 64'd1);
    step();                                     // A+4
    step();                                     // A+5
    check_output("rd_wait3_penable", 64'(PENABLE), 64'd1);
    step();                                     // A+6 ACCESS, slave ready
    PREADY = 4'b1000;
    check_output("rd_wait4_hready", 64'(HREADY), 64'd0);
    step();                                     // A+7
    check_output("rd_done_hready", 64'(HREADY), 64'd1);
    check_output("rd_done_hresp", 64'(HRESP), 64'd0);
    check_output("rd_done_hrdata", 64'(HRDATA), 64'h1234_5678);
    check_output("rd_done_psel", 64'(PSEL), 64'd0);

    // Slave error on a read from slave 2
    PREADY  = 4'b0100;
    PSLVERR = 4'b0100;
    PRDATA  = {32'h0, 32'hAAAA_5555, 32'h0, 32'h0};
    apply_stimulus(32'h0000_2000, 1'b0);
    step();                                     // A+1
    ahb_idle();
    step();                                     // A+2 SETUP
    check_output("err_setup_psel", 64'(PSEL), 64'h4);
    step();                                     // A+3 ACCESS
    step();                                     // A+4 ERR1
    check_output("err1_hready", 64'(HREADY), 64'd0);
    check_output("err1_hresp", 64'(HRESP), 64'd1);
    check_output("err1_psel", 64'(PSEL), 64'd0);
    check_output("err1_penable", 64'(PENABLE), 64'd0);
    step();                                     // A+5 ERR2
    check_output("err2_hready", 64'(HREADY), 64'd1);
    check_output("err2_hresp", 64'(HRESP), 64'd1);
    check_output("err2_hrdata", 64'(HRDATA), 64'h1234_5678);
    step();                                     // A+6 IDLE
    check_output("err_idle_hresp", 64'(HRESP), 64'd0);
    PSLVERR = 4'b0000;

    // Out-of-range slave index 5. A write is issued back-to-back from ERR2.
    apply_stimulus(32'h0000_5000, 1'b0);
    step();                                     // A+1 CAPTURE
    ahb_idle();
    check_output("bad_capture_psel", 64'(PSEL), 64'd0);
    step();                                     // A+2 ERR1
    check_output("bad_err1_hready", 64'(HREADY), 64'd0);
    check_output("bad_err1_hresp", 64'(HRESP), 64'd1);
    check_output("bad_err1_psel", 64'(PSEL), 64'd0);
    step();                                     // A+3 ERR2
    check_output("bad_err2_hready", 64'(HREADY), 64'd1);
    check_output("bad_err2_hresp", 64'(HRESP), 64'd1);
    PREADY = 4'b0001;
    apply_stimulus(32'h0000_0008, 1'b1);
    step();                                     // CAPTURE
    ahb_idle();
    HWDATA = 32'h0BAD_F00D;
    check_output("b2b_capture_hready", 64'(HREADY), 64'd0);
    step();                                     // SETUP
    check_output("b2b_setup_psel", 64'(PSEL), 64'h1);
    check_output("b2b_setup_pwdata", 64'(PWDATA), 64'h0BAD_F00D);
    check_output("b2b_setup_paddr", 64'(PADDR), 64'h8);
    step();                                     // ACCESS
    check_output("b2b_access_penable", 64'(PENABLE), 64'd1);
    step();                                     // IDLE
    check_output("b2b_done_hready", 64'(HREADY), 64'd1);
    check_output("b2b_done_hresp", 64'(HRESP), 64'd0);

    // Timeout: slave 1 never responds.
    PREADY = 4'b0000;
    apply_stimulus(32'h0000_1000, 1'b0);
    step();                                     // A+1
    ahb_idle();
    step();                                     // A+2 SETUP
    access_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (PENABLE) access_cycles++;
      else break;
    end
    check_output("to_access_cycles", 64'(access_cycles), 64'd16);
    check_output("to_err1_hready", 64'(HREADY), 64'd0);
    check_output("to_err1_hresp", 64'(HRESP), 64'd1);
    check_output("to_err1_psel", 64'(PSEL), 64'd0);
    step();                                     // ERR2
    check_output("to_err2_hready", 64'(HREADY), 64'd1);
    check_output("to_err2_hresp", 64'(HRESP), 64'd1);
    step();                                     // IDLE
    check_output("to_idle_hresp", 64'(HRESP), 64'd0);

    // Reset asserted in the middle of ACCESS
    apply_stimulus(32'h0000_1000, 1'b0);
    step();
    ahb_idle();
    step();                                     // SETUP
    step();                                     // ACCESS
    check_output("rstacc_penable_before", 64'(PENABLE), 64'd1);
    HRESETn = 1'b0;
    #1;
    check_output("rstacc_psel", 64'(PSEL), 64'd0);
    check_output("rstacc_penable", 64'(PENABLE), 64'd0);
    check_output("rstacc_hready", 64'(HREADY), 64'd1);
    check_output("rstacc_hrdata", 64'(HRDATA), 64'd0);
    step();
    HRESETn = 1'b1;
    step();
    check_output("rstacc_idle_psel", 64'(PSEL), 64'd0);

    // A normal read after reset
    PREADY = 4'b0100;
    PRDATA = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
    apply_stimulus(32'h0000_2004, 1'b0);
    step();
    ahb_idle();
    step();
    check_output("post_setup_psel", 64'(PSEL), 64'h4);
    step();
    step();
    check_output("post_done_hready", 64'(HREADY), 64'd1);
    check_output("post_done_hresp", 64'(HRESP), 64'd0);
    check_output("post_done_hrdata", 64'(HRDATA), 64'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errors);
    $finish;
  end

  // Last-resort guard so the run always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    num_errors++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge_mc.md
AHB_APB_BRIDGE_MC -- requirements
Module: ahb_apb_bridge_mc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AHB/APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, AHB/APB data width; full-word transfers only.
REQ-003 SHALL have parameter NUM_SLV, default 4, APB slave count, legal 1..16.
REQ-004 SHALL have parameter SEL_LSB, default 12, LSB of the 4-bit slave-index field in HADDR.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before forced error, legal 1..255.
REQ-006 SHALL use one clock and an asynchronous active-low reset; ports clk and HRESETn.
REQ-007 Ports (name direction width meaning):
 clk        in   1                clock, rising edge
 HRESETn    in   1                async active-low reset
 HSELAHB    in   1                bridge select
 HADDR      in   ADDR_W           AHB address
 HTRANS     in   2                AHB transfer type
 HWRITE     in   1                1 = write
 HWDATA     in   DATA_W           write data, valid in the cycle after the address phase
 HRDATA     out  DATA_W           registered read data
 HREADY     out  1                transfer done / bridge ready
 HRESP      out  1                1 = ERROR
 PADDR      out  ADDR_W           APB address
 PWDATA     out  DATA_W           APB write data
 PWRITE     out  1                APB direction
 PSEL       out  NUM_SLV          one-hot slave select
 PENABLE    out  1                APB access phase
 PRDATA     in   NUM_SLV*DATA_W   slave i read data in slice [i*DATA_W +: DATA_W]
 PREADY     in   NUM_SLV          per-slave ready
 PSLVERR    in   NUM_SLV          per-slave error

Function
REQ-008 Valid transfer SHALL be HSELAHB=1 & HTRANS[1]=1 & HREADY=1 at the clk edge; IDLE/BUSY SHALL be ignored.
REQ-009 FSM states SHALL be IDLE, CAPTURE, SETUP, ACCESS, ERR1, ERR2.
REQ-010 IDLE: HREADY=1, HRESP=0; on a valid transfer, latch HADDR/HWRITE and slave index idx=HADDR[SEL_LSB+:4], then go to CAPTURE.
REQ-011 CAPTURE: HREADY=0; latch HWDATA into PWDATA at the end of the cycle for writes, hold PWDATA for reads; go to ERR1 if idx>=NUM_SLV, else go to SETUP.
REQ-012 SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latches; go to ACCESS.
REQ-013 ACCESS: PSEL[idx]=1, PENABLE=1; PADDR/PWDATA/PWRITE SHALL stay stable from SETUP through the end of ACCESS.
REQ-014 In ACCESS, PREADY[idx]=1 & PSLVERR[idx]=0 SHALL capture PRDATA slice idx into HRDATA on reads and go to IDLE; HREADY=1 in the following cycle.
REQ-015 In ACCESS, PREADY[idx]=1 & PSLVERR[idx]=1 SHALL go to ERR1; HRDATA SHALL stay unchanged.
REQ-016 A timeout counter SHALL clear on SETUP and increment each ACCESS cycle with PREADY[idx]=0; on reaching TIMEOUT_CYC, go to ERR1.
REQ-017 ERR1: HREADY=0, HRESP=1, PSEL=0, PENABLE=0; ERR2: HREADY=1, HRESP=1; ERR2 SHALL go to IDLE, or to CAPTURE on a valid transfer.
REQ-018 The bridge SHALL accept a new address phase only in IDLE and ERR2; back-to-back transfers with no idle gap SHALL be supported.
REQ-019 Zero-wait APB latency: address phase at cycle A, then CAPTURE A+1, SETUP A+2, ACCESS A+3, HREADY=1 with data at A+4.
REQ-020 PREADY/PSLVERR/PRDATA of non-selected slaves SHALL be ignored; at most one PSEL bit high at any time.

Reset
REQ-021 HRESETn=0 SHALL asynchronously force state IDLE, counter 0, HREADY=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0.
REQ-022 Reset during any state SHALL abort the transfer immediately with no further APB activity; after release the bridge is in IDLE.

Verification
REQ-023 Write HADDR=0x0000_1004, HWDATA=0xDEAD_BEEF, slave 1 PREADY=1 -> PSEL=4'b0010 at A+2, PENABLE at A+3, PWDATA=0xDEAD_BEEF, HREADY=1 at A+4, HRESP=0.
REQ-024 Read HADDR=0x0000_3010, slave 3 holds PREADY=0 for 3 ACCESS cycles, PRDATA=0x1234_5678 -> HRDATA=0x1234_5678, HREADY=1 at A+7.
REQ-025 Read slave 2 with PSLVERR=1 -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then IDLE; HRDATA unchanged.
REQ-026 HADDR=0x0000_5000 with NUM_SLV=4 -> no PSEL asserted, two-cycle ERROR response starting A+2.
REQ-027 PREADY stuck low with TIMEOUT_CYC=16 -> 16 ACCESS cycles, then PSEL/PENABLE drop and a two-cycle ERROR response follows.
REQ-028 HRESETn asserted in ACCESS -> PSEL=0, PENABLE=0, HREADY=1 immediately; next valid transfer completes normally.
